// File: rtl/conv_pkg.sv
// Shared types for the convolution frame sequencer: FSM states and the
// per-advance position tag that travels alongside the engine pipeline.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } seq_state_t;

   typedef struct packed {
      logic valid;
      logic sof;
      logic eol;
      logic eof;
   } conv_tag_t;

   localparam int unsigned KERNEL_DIM_DEFAULT = 3;

endpackage

// File: rtl/conv_tag_pipe.sv
// Tag delay line matching the engine latency; advances only when the engine
// advances so the tail tag always describes the current conv_result.
module conv_tag_pipe
   import conv_pkg::*;
#(
   parameter int unsigned PIPE_LAT = 3
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   input  logic      clr,
   input  conv_tag_t tag_in,
   output conv_tag_t tag_out
);

   conv_tag_t stage [PIPE_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= tag_in;
         for (int unsigned i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[PIPE_LAT-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 line-buffered convolution engine:
// gates pixels into the engine, drains it at end of frame, emits interior results.
module conv_frame_sequencer
   import conv_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned ROW_SIZE   = 540,
   parameter int unsigned NUM_ROWS   = 540,
   parameter int unsigned KERNEL_DIM = KERNEL_DIM_DEFAULT,
   parameter int unsigned PIPE_LAT   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [WORD_SIZE-1:0] in_pixel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] conv_pix,
   output logic                 conv_en,
   output logic                 conv_clr,
   input  logic [WORD_SIZE-1:0] conv_result,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_valid,
   output logic                 out_sof,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int unsigned COL_W = $clog2(ROW_SIZE);
   localparam int unsigned ROW_W = $clog2(NUM_ROWS);
   localparam int unsigned FL_W  = $clog2(PIPE_LAT + 1);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_SIZE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(NUM_ROWS - 1);
   localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_DIM - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_DIM - 1);
   localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(PIPE_LAT - 1);

   seq_state_t       state, state_nx;
   logic [COL_W-1:0] col, col_nx;
   logic [ROW_W-1:0] row, row_nx;
   logic [FL_W-1:0]  flush_cnt, flush_cnt_nx;
   conv_tag_t        push_tag, tail_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nx;
         col       <= col_nx;
         row       <= row_nx;
         flush_cnt <= flush_cnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      col_nx       = col;
      row_nx       = row;
      flush_cnt_nx = flush_cnt;
      in_ready     = 1'b0;
      conv_en      = 1'b0;
      conv_pix     = '0;
      conv_clr     = 1'b0;
      frame_done   = 1'b0;
      push_tag     = '0;
      // abort overrides everything, including a coincident start or pixel
      if (abort) begin
         state_nx = IDLE;
         conv_clr = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  conv_clr = 1'b1;
                  col_nx   = '0;
                  row_nx   = '0;
                  state_nx = RUN;
               end
            end
            RUN: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  conv_en        = 1'b1;
                  conv_pix       = in_pixel;
                  push_tag.valid = (row >= ROW_FIRST) && (col >= COL_FIRST);
                  push_tag.sof   = push_tag.valid && (row == ROW_FIRST) && (col == COL_FIRST);
                  push_tag.eol   = push_tag.valid && (col == COL_LAST);
                  push_tag.eof   = push_tag.valid && (row == ROW_LAST) && (col == COL_LAST);
                  if (col == COL_LAST) begin
                     col_nx = '0;
                     if (row == ROW_LAST) begin
                        row_nx       = '0;
                        flush_cnt_nx = '0;
                        state_nx     = FLUSH;
                     end else begin
                        row_nx = row + 1'b1;
                     end
                  end else begin
                     col_nx = col + 1'b1;
                  end
               end
            end
            FLUSH: begin
               conv_en = 1'b1;
               if (flush_cnt == FL_LAST) state_nx = DONE;
               else                      flush_cnt_nx = flush_cnt + 1'b1;
            end
            DONE: begin
               frame_done = 1'b1;
               state_nx   = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   conv_tag_pipe #(
      .PIPE_LAT (PIPE_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (conv_en),
      .clr     (conv_clr),
      .tag_in  (push_tag),
      .tag_out (tail_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pixel <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         if (conv_en && tail_tag.valid) begin
            out_pixel <= conv_result;
            out_valid <= 1'b1;
            out_sof   <= tail_tag.sof;
            out_eol   <= tail_tag.eol;
            out_eof   <= tail_tag.eof;
         end
      end
   end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Randomized frame-level bench: small 5x4 instance against a queue-based result
// model, plus a 40x30 ramp instance checked by raster position arithmetic.
module tb_conv_frame_sequencer;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int P  = 3;
   localparam int WB = 40;
   localparam int HB = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic       start = 0, abort = 0, in_valid = 0;
   logic [7:0] in_pixel = '0;
   logic       in_ready, conv_en, conv_clr, out_valid, out_sof, out_eol, out_eof, busy, frame_done;
   logic [7:0] conv_pix, conv_result, out_pixel;

   // instance B
   logic       start_b = 0, in_valid_b = 0;
   logic [7:0] in_pixel_b = '0;
   logic       in_ready_b, conv_en_b, conv_clr_b, out_valid_b, out_sof_b, out_eol_b, out_eof_b;
   logic       busy_b, frame_done_b;
   logic [7:0] conv_pix_b, conv_result_b, out_pixel_b;

   conv_frame_sequencer #(.WORD_SIZE(8), .ROW_SIZE(W), .NUM_ROWS(H), .KERNEL_DIM(3), .PIPE_LAT(P)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .conv_pix(conv_pix), .conv_en(conv_en), .conv_clr(conv_clr), .conv_result(conv_result),
      .out_pixel(out_pixel), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
      .out_eof(out_eof), .busy(busy), .frame_done(frame_done));

   conv_frame_sequencer #(.WORD_SIZE(8), .ROW_SIZE(WB), .NUM_ROWS(HB), .KERNEL_DIM(3), .PIPE_LAT(P)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
      .in_pixel(in_pixel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .conv_pix(conv_pix_b), .conv_en(conv_en_b), .conv_clr(conv_clr_b), .conv_result(conv_result_b),
      .out_pixel(out_pixel_b), .out_valid(out_valid_b), .out_sof(out_sof_b), .out_eol(out_eol_b),
      .out_eof(out_eof_b), .busy(busy_b), .frame_done(frame_done_b));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] eng_f(input logic [7:0] x);
      return {x[4:0], x[7:5]} ^ 8'h5A;
   endfunction

   // engine stand-in: result emerges PIPE_LAT advances after its pixel
   logic [7:0] ea0, ea1, ea2, eb0, eb1, eb2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea0 <= 0; ea1 <= 0; ea2 <= 0; eb0 <= 0; eb1 <= 0; eb2 <= 0;
      end else begin
         if (conv_clr) begin
            ea0 <= 0; ea1 <= 0; ea2 <= 0;
         end else if (conv_en) begin
            ea0 <= eng_f(conv_pix); ea1 <= ea0; ea2 <= ea1;
         end
         if (conv_clr_b) begin
            eb0 <= 0; eb1 <= 0; eb2 <= 0;
         end else if (conv_en_b) begin
            eb0 <= eng_f(conv_pix_b); eb1 <= eb0; eb2 <= eb1;
         end
      end
   end
   assign conv_result   = ea2;
   assign conv_result_b = eb2;

   typedef struct {
      logic [7:0] pix;
      logic       sof, eol, eof;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] pix_a[W*H];
   int         res_n = 0;
   bit         pin_on = 0;

   // compare process for instance A
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            res_n++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_pixel", out_pixel, e.pix);
               chk("out_flags", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
            end
            if (pin_on) begin
               chk("pin_sof", out_sof, res_n == 1);
               chk("pin_eol", out_eol, res_n == 3 || res_n == 6);
               chk("pin_eof", out_eof, res_n == 6);
            end
         end else begin
            chk("idle_flags", {out_sof, out_eol, out_eof}, 0);
         end
         if (in_ready) begin
            chk("conv_en_vs_accept", conv_en, in_valid);
            if (in_valid) chk("conv_pix_pass", conv_pix, in_pixel);
         end
         if (!busy) chk("in_ready_idle", in_ready, 0);
      end
   end

   // instance B: expected result position walks the interior in raster order
   int rb = 2, cb = 2, cnt_b = 0, eol_b = 0, eof_b = 0;
   always @(negedge clk) begin
      if (rst_n && out_valid_b) begin
         chk("b_pixel", out_pixel_b, eng_f(8'((rb * WB + cb) & 255)));
         chk("b_flags", {out_sof_b, out_eol_b, out_eof_b},
             {rb == 2 && cb == 2, cb == WB - 1, rb == HB - 1 && cb == WB - 1});
         cnt_b++;
         if (out_eol_b) eol_b++;
         if (out_eof_b) eof_b++;
         if (cb == WB - 1) begin cb = 2; rb++; end
         else cb++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // build expectations for the first n accepted pixels; results whose pipe
   // position was never reached (no flush) are excluded via 'limit'
   task automatic build_exp(input int n, input bit flushed);
      int limit;
      limit = flushed ? n - 1 : n - 1 - P;
      for (int k = 0; k <= limit; k++) begin
         int r, c;
         exp_t e;
         r = k / W;
         c = k % W;
         if (r >= 2 && c >= 2) begin
            e.pix = eng_f(pix_a[k]);
            e.sof = (r == 2 && c == 2);
            e.eol = (c == W - 1);
            e.eof = (r == H - 1 && c == W - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drive_pixels(input int n, input int mode);
      int sent = 0;
      int cyc = 0;
      bit v, rdy;
      while (sent < n) begin
         if (cyc > 4 * n + 20) begin
            chk("accept_timeout", sent, n);
            break;
         end
         case (mode)
            0:       v = 1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         in_valid = v;
         in_pixel = v ? pix_a[sent] : 8'($urandom);
         @(negedge clk);
         rdy = in_ready;
         tick();
         if (v && rdy) sent++;
         cyc++;
      end
      in_valid = 0;
   endtask

   task automatic start_frame(input bit ramp);
      for (int k = 0; k < W * H; k++) pix_a[k] = ramp ? 8'(k * 7) : 8'($urandom);
      res_n = 0;
      start = 1;
      @(negedge clk);
      chk("start_clr", conv_clr, 1);
      chk("start_ready_low", in_ready, 0);
      tick();
      start = 0;
   endtask

   task automatic full_frame(input int mode, input bit ramp);
      start_frame(ramp);
      build_exp(W * H, 1);
      drive_pixels(W * H, mode);
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         chk("flush_en", {conv_en, in_ready, busy, frame_done}, 4'b1010);
         chk("flush_pix", conv_pix, 0);
         tick();
      end
      @(negedge clk);
      chk("frame_done", {frame_done, busy, out_eof}, 3'b111);
      tick();
      @(negedge clk);
      chk("idle_after_done", {frame_done, busy}, 0);
      tick();
      chk("result_count", res_n, 6);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_outs", {in_ready, conv_en, conv_clr, out_valid, out_sof, out_eol, out_eof, busy, frame_done}, 0);
      chk("rst_pix", {out_pixel, conv_pix}, 0);
      tick(); tick();
      rst_n = 1;
      tick();

      // back-to-back frame with literal pins on flag positions
      pin_on = 1;
      full_frame(0, 1);
      // same ramp frame with alternating valid
      full_frame(1, 1);
      pin_on = 0;

      // abort after 12 pixels (in_valid held high during abort)
      start_frame(0);
      build_exp(12, 0);
      drive_pixels(12, 0);
      in_valid = 1;
      abort = 1;
      @(negedge clk);
      chk("abort_cycle", {conv_clr, conv_en, in_ready}, 3'b100);
      tick();
      abort = 0;
      in_valid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_idle", {busy, frame_done, out_valid}, 0);
         tick();
      end
      chk("abort_queue", exp_q.size(), 0);

      // start during RUN is ignored, then the frame completes normally
      start_frame(0);
      start = 1;
      @(negedge clk);
      chk("start_in_run", {conv_clr, busy}, 2'b01);
      tick();
      start = 0;
      build_exp(W * H, 1);
      drive_pixels(W * H, 2);
      for (int i = 0; i < P + 3; i++) tick();
      chk("run_start_queue", exp_q.size(), 0);
      chk("run_start_idle", busy, 0);

      // start & abort together in IDLE: abort wins
      start = 1;
      abort = 1;
      @(negedge clk);
      chk("start_abort_clr", {conv_clr, busy}, 2'b10);
      tick();
      start = 0;
      abort = 0;
      @(negedge clk);
      chk("start_abort_idle", busy, 0);
      tick();

      // random frames
      for (int f = 0; f < 3; f++) full_frame(2, 0);

      // reset mid-RUN
      start_frame(0);
      build_exp(17, 0);
      drive_pixels(17, 0);
      @(negedge clk);
      tick();
      chk("pre_reset_queue", exp_q.size(), 0);
      in_valid = 1;
      rst_n = 0;
      #1;
      chk("midrun_rst_outs", {in_ready, conv_en, conv_clr, out_valid, out_sof, out_eol, out_eof, busy, frame_done}, 0);
      chk("midrun_rst_pix", {out_pixel, conv_pix}, 0);
      exp_q.delete();
      in_valid = 0;
      tick();
      rst_n = 1;
      tick();
      full_frame(2, 0);

      // large ramp frame on instance B
      start_b = 1;
      tick();
      start_b = 0;
      begin
         int sent = 0;
         int guard = 0;
         bit v, rdy;
         while (sent < WB * HB && guard < 4 * WB * HB) begin
            v = ($urandom_range(0, 4) != 0);
            in_valid_b = v;
            in_pixel_b = 8'(sent & 255);
            @(negedge clk);
            rdy = in_ready_b;
            tick();
            if (v && rdy) sent++;
            guard++;
         end
         in_valid_b = 0;
         chk("b_accepted", sent, WB * HB);
         guard = 0;
         while (!frame_done_b && guard < 20) begin
            @(negedge clk);
            if (!frame_done_b) tick();
            guard++;
         end
         chk("b_frame_done", frame_done_b, 1);
         tick();
         tick();
      end
      chk("b_count", cnt_b, 1064);
      chk("b_eol_count", eol_b, 28);
      chk("b_eof_count", eof_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
